// File: rtl/nibble_serial_mult.sv
// Iterative WIDTH x WIDTH unsigned multiplier: one nibble pair per cycle through a
// combinational 4x4 Vedic core, shifted partial products accumulated to 2*WIDTH bits.

module multiply4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] c
);

  function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
    logic t1, t2, t3, k1;
    t1 = x[1] & y[0];
    t2 = x[0] & y[1];
    t3 = x[1] & y[1];
    k1 = t1 & t2;
    return {t3 & k1, t3 ^ k1, t1 ^ t2, x[0] & y[0]};
  endfunction

  logic [3:0] w_q0, w_q1, w_q2, w_q3;

  // Urdhva-tiryagbhyam: vertical and crosswise 2x2 products
  assign w_q0 = vedic2x2(a[1:0], b[1:0]);
  assign w_q1 = vedic2x2(a[3:2], b[1:0]);
  assign w_q2 = vedic2x2(a[1:0], b[3:2]);
  assign w_q3 = vedic2x2(a[3:2], b[3:2]);

  assign c = {4'b0000, w_q0} + {2'b00, w_q1, 2'b00} + {2'b00, w_q2, 2'b00} + {w_q3, 4'b0000};

endmodule

module nibble_serial_mult #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int SH_W  = $clog2(8 * N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_a, r_b;
  logic [IDX_W-1:0]     r_i, r_j;
  logic [2*WIDTH-1:0]   r_acc, r_product;
  logic [3:0]           w_a_nib, w_b_nib;
  logic [7:0]           w_c;
  logic [SH_W-1:0]      w_shamt;
  logic [2*WIDTH-1:0]   w_pp, w_sum;
  logic                 w_last;

  assign w_last  = (r_i == LAST) && (r_j == LAST);
  assign w_a_nib = 4'(r_a >> (4 * int'(r_i)));
  assign w_b_nib = 4'(r_b >> (4 * int'(r_j)));
  assign w_shamt = SH_W'(4 * (int'(r_i) + int'(r_j)));
  assign w_pp    = (2*WIDTH)'(w_c) << w_shamt;
  assign w_sum   = r_acc + w_pp;

  multiply4x4 u_core (
    .a (w_a_nib),
    .b (w_b_nib),
    .c (w_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, nibble walk (j inner, i outer) and accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_i   <= '0;
            r_j   <= '0;
          end
        end
        S_RUN: begin
          r_acc <= w_sum;
          if (w_last) begin
            r_product <= w_sum;
            r_i       <= '0;
            r_j       <= '0;
          end else if (r_j == LAST) begin
            r_j <= '0;
            r_i <= r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign product   = r_product;

endmodule

// File: tb/tb_nibble_serial_mult.sv
// Directed bench for nibble_serial_mult (WIDTH=16) with hand-computed products.

module tb_nibble_serial_mult;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int n_pass;
  int n_total;

  nibble_serial_mult #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] av, input logic [15:0] bv);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    int          lat;
    int          busy_low;
    int          unstable;
    logic [15:0] ra, rb;
    logic [63:0] ref_p;

    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    tick();
    tick();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_product",   64'(product),   64'd0);
    chk("reset_busy",      64'(busy),      64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    rst = 1'b0;
    tick();

    // Basic product
    out_ready = 1'b0;
    start(16'h1234, 16'h5678);
    chk("basic_in_ready_low", 64'(in_ready), 64'd0);
    chk("basic_busy",         64'(busy),     64'd1);
    wait_done(lat);
    chk("basic_latency", 64'(lat),     64'd16);
    chk("basic_product", 64'(product), 64'h06260060);
    out_ready = 1'b1;
    tick();
    chk("basic_hs_out_valid", 64'(out_valid), 64'd0);
    chk("basic_hs_in_ready",  64'(in_ready),  64'd1);
    chk("basic_hs_held",      64'(product),   64'h06260060);

    // Maximum operands
    start(16'hFFFF, 16'hFFFF);
    wait_done(lat);
    chk("max_latency", 64'(lat),     64'd16);
    chk("max_product", 64'(product), 64'hFFFE0001);
    tick();

    // Zero operand, busy must stay high throughout
    out_ready = 1'b0;
    start(16'h0000, 16'hBEEF);
    lat      = 0;
    busy_low = 0;
    while (!out_valid && lat < 100) begin
      if (!busy) busy_low++;
      tick();
      lat++;
    end
    chk("zero_latency",   64'(lat),      64'd16);
    chk("zero_busy_low",  64'(busy_low), 64'd0);
    chk("zero_busy_done", 64'(busy),     64'd1);
    chk("zero_product",   64'(product),  64'd0);
    out_ready = 1'b1;
    tick();

    // Backpressure with new operands held on the input
    out_ready = 1'b0;
    start(16'h00FF, 16'h00FF);
    wait_done(lat);
    chk("bp_latency", 64'(lat),     64'd16);
    chk("bp_product", 64'(product), 64'h0000FE01);
    a        = 16'h0102;
    b        = 16'h0304;
    in_valid = 1'b1;
    unstable = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (product !== 32'h0000FE01 || out_valid !== 1'b1 || in_ready !== 1'b0) unstable++;
    end
    chk("bp_stable_cycles", 64'(unstable), 64'd0);
    chk("bp_in_ready_low",  64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_hs_not_captured", 64'(busy),     64'd0);
    chk("bp_hs_in_ready",     64'(in_ready), 64'd1);
    chk("bp_hs_product_held", 64'(product),  64'h0000FE01);
    tick();
    in_valid = 1'b0;
    chk("bp_captured_busy", 64'(busy), 64'd1);
    wait_done(lat);
    chk("bp2_latency", 64'(lat),     64'd16);
    chk("bp2_product", 64'(product), 64'h00030A08);
    tick();

    // Reset in the middle of a run
    out_ready = 1'b0;
    start(16'h00FF, 16'h0101);
    for (int k = 0; k < 6; k++) tick();
    chk("mid_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_product",   64'(product),   64'd0);
    chk("mid_rst_busy",      64'(busy),      64'd0);
    chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_post_out_valid", 64'(out_valid), 64'd0);
    chk("mid_post_busy",      64'(busy),      64'd0);
    start(16'h0003, 16'h0005);
    wait_done(lat);
    chk("mid_fresh_latency", 64'(lat),     64'd16);
    chk("mid_fresh_product", 64'(product), 64'h0000000F);
    out_ready = 1'b1;
    tick();

    // Back-to-back random pairs with out_ready tied high
    out_ready = 1'b1;
    for (int t = 0; t < 200; t++) begin
      ra       = 16'($urandom);
      rb       = 16'($urandom);
      a        = ra;
      b        = rb;
      in_valid = 1'b1;
      chk("rnd_in_ready", 64'(in_ready), 64'd1);
      tick();
      a        = 16'($urandom);
      b        = 16'($urandom);
      wait_done(lat);
      ref_p = {48'd0, ra} * {48'd0, rb};
      chk("rnd_latency", 64'(lat),     64'd16);
      chk("rnd_product", 64'(product), ref_p);
      tick();
      chk("rnd_hs_out_valid", 64'(out_valid), 64'd0);
    end
    in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nibble_serial_mult.md
Name: nibble_serial_mult

Overview:
- Iterative WIDTH x WIDTH unsigned multiplier built around one instance of the team's multiply4x4 Vedic core.
- multiply4x4 is combinational: 4-bit a, 4-bit b, 8-bit product c.
- This block is the sequencing stage around that core. It splits operands into nibbles, feeds one nibble pair per cycle, and accumulates the shifted 8-bit partial products into the full-width result.
- Valid/ready handshakes on input and output; sits between the operand source and the result consumer.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and >= 8.
- N (localparam), WIDTH/4, nibbles per operand; a multiplication takes N*N partial products.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  unsigned multiplicand
- b  input  WIDTH  unsigned multiplier
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  unsigned a*b
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, active-high): state=IDLE, product=0, out_valid=0, busy=0, accumulator=0, nibble indices i=j=0, operand registers=0.
- in_ready is combinational: (state==IDLE). It reads 1 while rst is held, but nothing is captured during reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On in_valid && in_ready at a clock edge: latch a and b, clear accumulator, set i=j=0, go to RUN.
  - Otherwise hold.
- RUN, each cycle:
  - Drive multiply4x4 with a_reg[4i+3:4i] and b_reg[4j+3:4j].
  - Do acc <= acc + (c << 4*(i+j)); acc is 2*WIDTH bits wide, with no truncation inside the range.
  - Index order: j increments; when j wraps from N-1 to 0, i increments.
  - On the edge that processes i=N-1, j=N-1: write the final sum into product, set out_valid=1, go to DONE.
  - RUN lasts exactly N*N cycles (16 for WIDTH=16).
  - a/b/in_valid are ignored while in RUN or DONE.
- Latency: out_valid rises on the N*N-th rising edge after the accepting edge.
- DONE:
  - out_valid=1; product held stable while out_ready=0 (backpressure can last any number of cycles).
  - On out_valid && out_ready at an edge: out_valid=0, go to IDLE. product keeps its last value until the next result is written.
- No overlap: a new operand pair is accepted at the earliest one cycle after the output handshake (in_ready=1 in IDLE).
- Arithmetic:
  - Result is exact unsigned a*b; the maximum (2^WIDTH-1)^2 fits in 2*WIDTH bits.
  - Partial product shift is 4*(i+j), with i+j ranging over 0..2N-2.
- Zero operands still take the full N*N cycles; there is no early termination.
- Reset mid-operation (RUN or DONE): the operation is discarded. Return to IDLE with all outputs at reset values; no stale out_valid after release.
- busy = (state != IDLE).

Test Plan:
- Basic product, WIDTH=16:
  - Stimulus: a=0x1234, b=0x5678, in_valid pulse.
  - Required: in_ready low on the next cycle; out_valid after exactly 16 edges; product=0x06260060.
- Maximum operands:
  - Stimulus: a=0xFFFF, b=0xFFFF.
  - Required: product=0xFFFE0001, no overflow or truncation.
- Zero operand:
  - Stimulus: a=0x0000, b=0xBEEF.
  - Required: product=0x00000000 after full 16-cycle latency; busy high throughout.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid; hold in_valid=1 with new operands the whole time.
  - Required: product stable; in_ready=0; new operands not captured until one cycle after the out handshake.
  - Then: next result is correct for the new operands.
- Reset mid-run:
  - Stimulus: start a=0x00FF, b=0x0101; assert rst at RUN cycle 7.
  - Required: out_valid=0, product=0, busy=0, in_ready=1.
  - Then: a fresh 0x0003*0x0005 completes with product=0x0000000F.
- Back-to-back random:
  - Stimulus: 200 random pairs with out_ready tied 1.
  - Required: every product matches the reference model; each transaction takes exactly 16 RUN cycles plus 1 DONE and 1 IDLE cycle.
